// File: rtl/note_env_if.sv
// Voice/mixer-facing signal bundle for the ADSR envelope stage.
// The master drives the note controls and sample; the slave (note_env) returns the enveloped sample and status.
interface note_env_if #(
  parameter int PCM_QUANT = 16,
  parameter int ENV_W     = 16
);
  logic                        gate;
  logic        [ENV_W-1:0]     atk;
  logic        [ENV_W-1:0]     dec;
  logic        [ENV_W-1:0]     sus;
  logic        [ENV_W-1:0]     rel;
  logic signed [PCM_QUANT-1:0] x;
  logic                        clr_note;
  logic signed [PCM_QUANT-1:0] y;
  logic        [ENV_W-1:0]     level;
  logic                        active;

  // Streaming, no handshake: x is taken every clk, and y is the product of that x and the level one clk later.
  modport master (
    output gate, atk, dec, sus, rel, x,
    input  clr_note, y, level, active
  );

  modport slave (
    input  gate, atk, dec, sus, rel, x,
    output clr_note, y, level, active
  );
endinterface

// File: rtl/note_env.sv
// ADSR amplitude envelope for one note voice: scales the voice sample by the level and drives the voice clr input.
// Optional NOTE_ENV_RETRIGGER_EN: a rise in RELEASE or SUSTAIN restarts hard from 0 with a 1-cycle clr_note pulse.
module note_env #(
  parameter int TICK_DIV  = 256,
  parameter int ENV_W     = 16,
  parameter int PCM_QUANT = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  note_env_if.slave  bus,
  output logic [2:0] dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_ATTACK  = 3'd1,
    S_DECAY   = 3'd2,
    S_SUSTAIN = 3'd3,
    S_RELEASE = 3'd4
  } state_t;

  localparam int              CNT_W   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);
  localparam logic [ENV_W-1:0] LVL_MAX  = '1;
  localparam int              PW      = PCM_QUANT + ENV_W + 1;

  state_t             state;
  logic               gate_q;
  logic [CNT_W-1:0]   cnt;
  logic               tick;
  logic               rise;
  logic               fall;
  logic [ENV_W:0]     atk_sum;
  logic [ENV_W:0]     dec_diff;
  logic               atk_full;
  logic               dec_hit;
  logic signed [PW-1:0] p;

  assign tick = (cnt == CNT_LAST);
  assign rise = bus.gate & ~gate_q;
  assign fall = ~bus.gate & gate_q;

  // One bit wider than the level so attack saturates instead of wrapping and decay cannot underflow.
  assign atk_sum  = {1'b0, bus.level} + {1'b0, bus.atk};
  assign dec_diff = {1'b0, bus.level} - {1'b0, bus.dec};
  assign atk_full = (bus.atk == '0) || (atk_sum >= {1'b0, LVL_MAX});
  assign dec_hit  = (bus.dec == '0) || dec_diff[ENV_W] || (dec_diff[ENV_W-1:0] <= bus.sus);

  // Level is treated as a non-negative fraction of full scale, so |y| never exceeds |x|.
  assign p = $signed(PW'(bus.x)) * $signed(PW'($signed({1'b0, bus.level})));

  assign dbg_state = state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gate_q <= 1'b0;
      cnt    <= '0;
    end else begin
      gate_q <= bus.gate;
      cnt    <= tick ? '0 : cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.y <= '0;
    end else begin
      bus.y <= PCM_QUANT'(p >>> ENV_W);
    end
  end

  // Gate edges are checked before the tick in every state so the level never steps on an edge cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= S_IDLE;
      bus.level    <= '0;
      bus.clr_note <= 1'b1;
      bus.active   <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          bus.level    <= '0;
          bus.clr_note <= 1'b1;
          if (rise) begin
            state        <= S_ATTACK;
            bus.clr_note <= 1'b0;
            bus.active   <= 1'b1;
          end
        end
        S_ATTACK: begin
          bus.clr_note <= 1'b0;
          if (fall) begin
            state <= S_RELEASE;
          end else if (tick) begin
            if (atk_full) begin
              bus.level <= LVL_MAX;
              state     <= S_DECAY;
            end else begin
              bus.level <= atk_sum[ENV_W-1:0];
            end
          end
        end
        S_DECAY: begin
          if (fall) begin
            state <= S_RELEASE;
          end else if (bus.level <= bus.sus) begin
            bus.level <= bus.sus;
            state     <= S_SUSTAIN;
          end else if (tick) begin
            if (dec_hit) begin
              bus.level <= bus.sus;
              state     <= S_SUSTAIN;
            end else begin
              bus.level <= dec_diff[ENV_W-1:0];
            end
          end
        end
        S_SUSTAIN: begin
          if (fall) begin
            state <= S_RELEASE;
`ifdef NOTE_ENV_RETRIGGER_EN
          end else if (rise) begin
            bus.clr_note <= 1'b1;
            bus.level    <= '0;
            state        <= S_ATTACK;
`endif
          end else begin
            bus.level <= bus.sus;
          end
        end
        S_RELEASE: begin
          if (rise) begin
`ifdef NOTE_ENV_RETRIGGER_EN
            bus.clr_note <= 1'b1;
            bus.level    <= '0;
`endif
            state <= S_ATTACK;
          end else if (tick) begin
            if ((bus.rel == '0) || (bus.level <= bus.rel)) begin
              bus.level    <= '0;
              bus.clr_note <= 1'b1;
              bus.active   <= 1'b0;
              state        <= S_IDLE;
            end else begin
              bus.level <= bus.level - bus.rel;
            end
          end
        end
        default: begin
          state        <= S_IDLE;
          bus.level    <= '0;
          bus.clr_note <= 1'b1;
          bus.active   <= 1'b0;
        end
      endcase
    end
  end

endmodule
